finv_sched: RTL and testbench
=============================

FINV_SCHED -- requirements
Module: finv_sched

Interface
REQ-001 Parameter LAT, default 4, fixed latency in cycles from operand on fu_s to result on fu_d of the attached reciprocal pipeline.
REQ-002 Parameter QDEPTH, default 4, result-queue depth per requester (power of two, ≥2).
REQ-003 Parameter TAGW, default 4, tag width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  2  requester i has an operand.
REQ-008 req_ready  out  2  requester i's operand accepted this cycle.
REQ-009 req_data  in  64  operand of requester i at [32i+31:32i], IEEE single.
REQ-010 req_tag  in  2*TAGW  tag of requester i at [TAGW*i+TAGW-1:TAGW*i].
REQ-011 fu_s  out  32  operand to the reciprocal pipeline.
REQ-012 fu_d  in  32  pipeline result, valid LAT cycles after matching fu_s.
REQ-013 rsp_valid  out  2  result queue i non-empty.
REQ-014 rsp_ready  in  2  requester i consumes its head result.
REQ-015 rsp_data  out  64  head result of queue i, same packing as req_data.
REQ-016 rsp_tag  out  2*TAGW  head tag of queue i.
REQ-017 idle  out  1  no operation in flight and both queues empty.

Function
REQ-018 Requester i eligible when req_valid[i]=1 and credit[i]>0; at most one issue per cycle.
REQ-019 One eligible: it is granted; both eligible: grant index rr; after any grant rr SHALL become the other index.
REQ-020 req_ready[i]=1 only for the granted requester (combinational); handshake = req_valid&req_ready.
REQ-021 fu_s = granted operand in an issue cycle, else 32'h0.
REQ-022 Issue in cycle t SHALL push {valid,id,tag} into a LAT-deep tracking shift register; the entry reaches the tail in cycle t+LAT, aligned with fu_d.
REQ-023 Valid tail entry SHALL write {fu_d,tag} into queue[id] at the end of cycle t+LAT; rsp_valid[id] visible from cycle t+LAT+1.
REQ-024 Queues strictly FIFO; pop when rsp_valid[i]&rsp_ready[i]; push and pop to the same queue in one cycle both take effect, occupancy unchanged.
REQ-025 credit[i] (width log2(QDEPTH)+1) = QDEPTH minus in-flight and queued entries of i: decrement on issue, increment on pop, unchanged when both occur; a queue can never overflow.
REQ-026 Issues to one requester proceed independently of the other's back-pressure.
REQ-027 idle=1 iff tracking register holds no valid entry and both queues empty.

Reset
REQ-028 In a cycle with rst=1: req_ready=00, fu_s=0.
REQ-029 After rst: tracking valid bits 0, queues empty, rsp_valid=00, credit=QDEPTH each, rr=0, idle=1.
REQ-030 Results of operations issued before reset SHALL never appear on rsp_valid, although the pipeline still drains them.

Verification
REQ-031 req0 0x40000000 tag 3 issued cycle 0, rsp_ready=11 -> rsp_valid[0]=1 in cycle 5 only, rsp_data[31:0]=0x3F000000, tag 3.
REQ-032 req1 0x3F800000 tag 0xF -> rsp_data[63:32]=0x3F800000, rsp_tag[7:4]=0xF, rsp_valid[0] stays 0.
REQ-033 Both req_valid held 1 after reset, rsp_ready=11 -> grants 0,1,0,1... one per cycle; results return in issue order per requester.
REQ-034 rsp_ready[0]=0, req0 held valid -> exactly 4 issues then req_ready[0]=0; req1 continues; one pop of queue 0 -> exactly one further req0 issue.
REQ-035 Queue 0 holding 1 entry, pop and tail-write same cycle -> occupancy stays 1, new head is the later result.
REQ-036 rst asserted with 3 operations in flight -> next cycle idle=1, rsp_valid=00, and it stays 00 for the following LAT+2 cycles with no new requests.

Source files
------------

// File: rtl/finv_sched.sv
// Two-requester issue scheduler for a fixed-latency reciprocal pipeline.
// Tracks in-flight operations and returns results through per-requester FIFOs.
module finv_sched #(
   parameter int LAT    = 4,
   parameter int QDEPTH = 4,
   parameter int TAGW   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [63:0]       req_data,
   input  logic [2*TAGW-1:0] req_tag,
   output logic [31:0]       fu_s,
   input  logic [31:0]       fu_d,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [63:0]       rsp_data,
   output logic [2*TAGW-1:0] rsp_tag,
   output logic              idle
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   // Handshakes: a transfer happens in a cycle where valid and ready are both
   // high; ready never depends on anything registered later than this cycle.
   logic [CW-1:0]   credit [2];
   logic            rr;
   logic [1:0]      elig;
   logic [1:0]      grant;
   logic            issue;
   logic            gid;
   logic [TAGW-1:0] gtag;

   logic [LAT-1:0]  trk_v;
   logic [LAT-1:0]  trk_id;
   logic [TAGW-1:0] trk_tag [LAT];
   logic            tail_v;
   logic            tail_id;
   logic [TAGW-1:0] tail_tag;

   logic [31:0]     q_data [2][QDEPTH];
   logic [TAGW-1:0] q_tag  [2][QDEPTH];
   logic [PW-1:0]   wp     [2];
   logic [PW-1:0]   rp     [2];
   logic [CW-1:0]   cnt    [2];
   logic [1:0]      push;
   logic [1:0]      pop;

   always_comb begin
      elig  = 2'b00;
      grant = 2'b00;
      for (int i = 0; i < 2; i++) begin
         elig[i] = req_valid[i] && (credit[i] != '0);
      end
      if (!rst) begin
         case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
      issue     = |grant;
      gid       = grant[1];
      req_ready = grant;
      gtag      = gid ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
      fu_s      = 32'h0;
      if (issue) begin
         fu_s = gid ? req_data[63:32] : req_data[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= 1'b0;
      end else if (issue) begin
         rr <= ~gid;
      end
   end

   // Tracking shift register; clearing the valid bits on reset discards any
   // result the pipeline is still draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_v <= '0;
      end else begin
         trk_v[0] <= issue;
         for (int k = 1; k < LAT; k++) begin
            trk_v[k] <= trk_v[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      trk_id[0]  <= gid;
      trk_tag[0] <= gtag;
      for (int k = 1; k < LAT; k++) begin
         trk_id[k]  <= trk_id[k-1];
         trk_tag[k] <= trk_tag[k-1];
      end
   end

   always_comb begin
      tail_v   = trk_v[LAT-1];
      tail_id  = trk_id[LAT-1];
      tail_tag = trk_tag[LAT-1];
      push     = {tail_v & tail_id, tail_v & ~tail_id};
      pop      = 2'b00;
      rsp_valid = 2'b00;
      rsp_data  = '0;
      rsp_tag   = '0;
      for (int i = 0; i < 2; i++) begin
         rsp_valid[i]              = (cnt[i] != '0);
         pop[i]                    = rsp_valid[i] & rsp_ready[i];
         rsp_data[32*i +: 32]      = q_data[i][rp[i]];
         rsp_tag[TAGW*i +: TAGW]   = q_tag[i][rp[i]];
      end
      idle = (trk_v == '0) && (cnt[0] == '0) && (cnt[1] == '0);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            q_data[i][wp[i]] <= fu_d;
            q_tag[i][wp[i]]  <= tail_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            wp[i]  <= '0;
            rp[i]  <= '0;
            cnt[i] <= '0;
         end else begin
            if (push[i]) begin
               wp[i] <= wp[i] + PW'(1);
            end
            if (pop[i]) begin
               rp[i] <= rp[i] + PW'(1);
            end
            if (push[i] && !pop[i]) begin
               cnt[i] <= cnt[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
               cnt[i] <= cnt[i] - CW'(1);
            end
         end
      end
   end

   // Credits cover both in-flight and queued results, so a queue cannot overflow.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            credit[i] <= CW'(QDEPTH);
         end else if (grant[i] && !pop[i]) begin
            credit[i] <= credit[i] - CW'(1);
         end else if (!grant[i] && pop[i]) begin
            credit[i] <= credit[i] + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_finv_sched.sv
// Bench for finv_sched: models the reciprocal pipeline and checks every cycle
// against a queue-based reference of grants, in-flight results and FIFOs.
module tb_finv_sched;

   localparam int LAT    = 4;
   localparam int QDEPTH = 4;
   localparam int TAGW   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_data;
   logic [7:0]  req_tag;
   logic [31:0] fu_s;
   logic [31:0] fu_d;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [63:0] rsp_data;
   logic [7:0]  rsp_tag;
   logic        idle;

   finv_sched #(.LAT(LAT), .QDEPTH(QDEPTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_tag(req_tag),
      .fu_s(fu_s), .fu_d(fu_d),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .idle(idle)
   );

   always #5 clk = ~clk;

   // Stand-in reciprocal: exact for powers of two, a fixed scramble otherwise.
   function automatic logic [31:0] recip(input logic [31:0] x);
      logic [8:0] e;
      if (x[22:0] == 23'h0 && x[30:23] != 8'h00 && x[30:23] != 8'hFF) begin
         e = 9'd254 - {1'b0, x[30:23]};
         return {x[31], e[7:0], 23'h0};
      end
      return x ^ 32'h5A5A5A5A;
   endfunction

   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= recip(fu_s);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign fu_d = pipe[LAT-1];

   typedef struct {
      int          due;
      bit          id;
      logic [35:0] ent;
   } fl_t;

   fl_t         fl_q[$];
   logic [35:0] exp_q0[$];
   logic [35:0] exp_q1[$];
   bit          rr_m;
   int          cyc;
   int          n_cmp;
   int          n_err;

   logic [1:0]  obs_ready;
   logic [1:0]  obs_rv;
   logic [63:0] obs_d;
   logic [7:0]  obs_t;
   logic        obs_idle;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int credit_m(input bit i);
      int n;
      n = 0;
      foreach (fl_q[k]) if (fl_q[k].id == i) n++;
      n += i ? exp_q1.size() : exp_q0.size();
      return QDEPTH - n;
   endfunction

   task automatic step(input logic rst_i, input logic [1:0] v, input logic [63:0] d,
                       input logic [7:0] t, input logic [1:0] rr_i);
      logic [1:0]  g;
      logic        e0, e1, gid;
      logic [31:0] op;
      logic [3:0]  tg;
      fl_t         f;
      rst = rst_i; req_valid = v; req_data = d; req_tag = t; rsp_ready = rr_i;
      #1;
      e0 = v[0] && (credit_m(1'b0) > 0);
      e1 = v[1] && (credit_m(1'b1) > 0);
      g  = 2'b00;
      if (!rst_i) begin
         if (e0 && e1) g = rr_m ? 2'b10 : 2'b01;
         else g = {e1, e0};
      end
      gid = g[1];
      op  = gid ? d[63:32] : d[31:0];
      tg  = gid ? t[7:4] : t[3:0];
      obs_ready = req_ready; obs_rv = rsp_valid; obs_d = rsp_data;
      obs_t = rsp_tag; obs_idle = idle;
      check("req_ready", req_ready, g);
      check("fu_s", fu_s, (g != 2'b00) ? op : 32'h0);
      check("rsp_valid", rsp_valid, {exp_q1.size() > 0, exp_q0.size() > 0});
      if (exp_q0.size() > 0) check("rsp0_head", {rsp_tag[3:0], rsp_data[31:0]}, exp_q0[0]);
      if (exp_q1.size() > 0) check("rsp1_head", {rsp_tag[7:4], rsp_data[63:32]}, exp_q1[0]);
      check("idle", idle, fl_q.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0);
      if (rst_i) begin
         fl_q.delete(); exp_q0.delete(); exp_q1.delete(); rr_m = 1'b0;
      end else begin
         if (rr_i[0] && exp_q0.size() > 0) void'(exp_q0.pop_front());
         if (rr_i[1] && exp_q1.size() > 0) void'(exp_q1.pop_front());
         while (fl_q.size() > 0 && fl_q[0].due == cyc) begin
            f = fl_q.pop_front();
            if (f.id) exp_q1.push_back(f.ent);
            else exp_q0.push_back(f.ent);
         end
         if (g != 2'b00) begin
            f.due = cyc + LAT; f.id = gid; f.ent = {tg, recip(op)};
            fl_q.push_back(f);
            rr_m = ~gid;
         end
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'b00, 64'h0, 8'h0, 2'b11);
   endtask

   int n0, n1;
   logic [1:0] rv;

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; rr_m = 1'b0;
      rst = 1'b1; req_valid = 2'b00; req_data = 64'h0; req_tag = 8'h0; rsp_ready = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Single requester-0 operation: 2.0 -> 0.5, result visible in cycle 5 only.
      for (int k = 0; k < 8; k++) begin
         step(1'b0, (k == 0) ? 2'b01 : 2'b00, 64'h0000_0000_4000_0000, 8'h03, 2'b11);
         check("r031_valid0", obs_rv[0], k == 5);
         if (k == 5) begin
            check("r031_data", obs_d[31:0], 32'h3F000000);
            check("r031_tag", obs_t[3:0], 4'h3);
         end
      end

      // Requester 1 lands in queue 1 only.
      for (int k = 0; k < 8; k++) begin
         step(1'b0, (k == 0) ? 2'b10 : 2'b00, 64'h3F80_0000_0000_0000, 8'hF0, 2'b11);
         check("r032_valid0", obs_rv[0], 1'b0);
         if (k == 5) begin
            check("r032_valid1", obs_rv[1], 1'b1);
            check("r032_data", obs_d[63:32], 32'h3F800000);
            check("r032_tag", obs_t[7:4], 4'hF);
         end
      end

      // Both requesting after reset: alternate 0,1,0,1.
      step(1'b1, 2'b00, 64'h0, 8'h0, 2'b00);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'b11, {$urandom, $urandom}, 8'($urandom), 2'b11);
         check("r033_grant", obs_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle_cycles(LAT + 3);
      check("r033_idle", obs_idle, 1'b1);

      // Back-pressure on queue 0 stops requester 0 after QDEPTH issues.
      step(1'b1, 2'b00, 64'h0, 8'h0, 2'b00);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 2'b11, {$urandom, $urandom}, 8'($urandom), 2'b10);
         n0 += int'(obs_ready[0]);
         n1 += int'(obs_ready[1]);
      end
      check("r034_n0", n0, QDEPTH);
      check("r034_ready0", obs_ready[0], 1'b0);
      check("r034_n1_ge6", n1 >= 6, 1'b1);
      step(1'b0, 2'b11, {$urandom, $urandom}, 8'($urandom), 2'b11);
      n0 = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'b11, {$urandom, $urandom}, 8'($urandom), 2'b10);
         n0 += int'(obs_ready[0]);
      end
      check("r034_one_more", n0, 1);
      idle_cycles(QDEPTH + LAT + 4);

      // Pop and tail-write to queue 0 in the same cycle.
      step(1'b1, 2'b00, 64'h0, 8'h0, 2'b00);
      for (int k = 0; k < 9; k++) begin
         step(1'b0, (k < 2) ? 2'b01 : 2'b00,
              (k == 0) ? 64'h0000_0000_4000_0000 : 64'h0000_0000_4080_0000,
              (k == 0) ? 8'h01 : 8'h02, (k == 5) ? 2'b01 : 2'b00);
         if (k == 5) check("r035_first", obs_d[31:0], 32'h3F000000);
         if (k >= 6) begin
            check("r035_valid", obs_rv[0], 1'b1);
            check("r035_head", {obs_t[3:0], obs_d[31:0]}, {4'h2, 32'h3E800000});
         end
      end
      idle_cycles(4);

      // Reset with three operations in flight discards them.
      for (int k = 0; k < 3; k++) begin
         step(1'b0, (k == 1) ? 2'b10 : 2'b01, {$urandom, $urandom}, 8'($urandom), 2'b11);
      end
      step(1'b1, 2'b00, 64'h0, 8'h0, 2'b11);
      for (int k = 0; k < LAT + 3; k++) begin
         step(1'b0, 2'b00, 64'h0, 8'h0, 2'b11);
         check("r036_idle", obs_idle, 1'b1);
         check("r036_rsp_valid", obs_rv, 2'b00);
      end

      // Randomized traffic with phases of heavy back-pressure and rare resets.
      for (int n = 0; n < 3000; n++) begin
         logic [63:0] d;
         if ((n / 400) % 2 == 1) rv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         else rv = 2'($urandom_range(0, 3));
         d = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) d[22:0] = 23'h0;
         if ($urandom_range(0, 3) == 0) d[54:32] = 23'h0;
         step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)), d, 8'($urandom), rv);
      end
      idle_cycles(QDEPTH * 2 + LAT + 4);
      check("final_idle", obs_idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
